picorv32_mem_arbiter: RTL and testbench
=======================================

// Module: picorv32_mem_arbiter
// PURPOSE
//  Shares one PicoRV32 native memory port (slave side) between two native-interface masters (m0, m1).
//  Round-robin arbitration; a grant is held until the slave responds.
//  A programmable wait-state watchdog terminates hung transactions with an error read value.
//  Sits between two cores (or a core and a DMA/debug master) and a single memory/bus slave.
// PARAMETERS
//  TIMEOUT_CYCLES  255           slave wait cycles before forced completion; 0 disables; max 65535
//  ERR_RDATA       32'hDEADBEEF  read data returned on timeout
// PORTS
//  clk           in   1   clock, all state on posedge
//  resetn        in   1   asynchronous active-low reset
//  m0_mem_valid  in   1   master 0 request
//  m0_mem_instr  in   1   master 0 request is instruction fetch
//  m0_mem_addr   in   32  master 0 byte address
//  m0_mem_wdata  in   32  master 0 write data
//  m0_mem_wstrb  in   4   master 0 byte strobes, 0 = read
//  m0_mem_ready  out  1   master 0 completion, 1-cycle pulse
//  m0_mem_rdata  out  32  master 0 read data, valid with m0_mem_ready
//  m1_*          --   --  identical set for master 1
//  mem_valid     out  1   slave request
//  mem_instr     out  1   slave instr flag
//  mem_addr      out  32  slave address
//  mem_wdata     out  32  slave write data
//  mem_wstrb     out  4   slave strobes
//  mem_ready     in   1   slave completion
//  mem_rdata     in   32  slave read data, valid with mem_ready
//  grant_id      out  1   current/last owner (0/1)
//  busy          out  1   state != IDLE
//  timeout_err   out  1   1-cycle pulse, coincident with the upstream ready of a timed-out transaction
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE.
//   mem_valid/instr/addr/wdata/wstrb=0, m*_mem_ready=0, rdata_q=0, wait_cnt=0.
//   last_owner=1 (first tie goes to m0), grant_id=0, timeout_err=0.
//   Outputs drop the same cycle resetn falls; an in-flight transaction is abandoned with no upstream ready.
//  FSM: IDLE -> ACTIVE -> RESP -> IDLE.
//  IDLE:
//   - If exactly one mN_mem_valid: owner=N.
//   - If both: owner=~last_owner.
//   - Latch owner's instr/addr/wdata/wstrb into slave-side regs; wait_cnt=0; go ACTIVE.
//  ACTIVE: mem_valid=1, slave-side fields held stable.
//   - mem_ready=1: rdata_q<=mem_rdata, mem_valid<=0, go RESP.
//   - else if TIMEOUT_CYCLES!=0 and wait_cnt==TIMEOUT_CYCLES-1: rdata_q<=ERR_RDATA, err_q<=1, mem_valid<=0, go RESP.
//   - else wait_cnt<=wait_cnt+1 (16 bit, never wraps in range).
//   - mem_ready in the same cycle as the limit: ready wins, normal completion, no error.
//  RESP: owner's mN_mem_ready=1 for exactly one cycle; timeout_err=err_q.
//   Then last_owner<=owner, err_q<=0, go IDLE.
//  Non-owner mN_mem_ready is always 0.
//  m0_mem_rdata = m1_mem_rdata = rdata_q; meaningful only with the matching ready.
//  Latency: upstream valid @t -> mem_valid @t+1; slave ready @t+1+k -> upstream ready @t+2+k.
//   Minimum 3 cycles per transaction; 1 idle-state cycle between transactions.
//  Owner dropping valid during ACTIVE is a protocol violation.
//   The transaction still completes and the response is still delivered.
//  Write responses: rdata_q captures mem_rdata regardless; masters ignore it.
//  grant_id=owner from IDLE exit until next grant.
// TESTING
//  1. m0 read 0x100, slave ready 1 cycle after mem_valid with 0x12345678.
//     -> mem_addr=0x100 @t+1, m0_mem_ready @t+3 with rdata 0x12345678, m1_mem_ready never 1.
//  2. After reset, m0 (0x10) and m1 (0x20) valid together, held.
//     -> slave sees 0x10 then 0x20; grant_id 0 then 1.
//  3. m1 write 0x40, wstrb 4'b0011, wdata 0xA5A55A5A.
//     -> identical fields on slave for whole ACTIVE, m1_mem_ready one pulse, timeout_err 0.
//  4. TIMEOUT_CYCLES=4, slave never ready, m0 read.
//     -> mem_valid high exactly 4 cycles; m0_mem_ready with 0xDEADBEEF; timeout_err 1 cycle.
//  5. TIMEOUT_CYCLES=4, mem_ready in the 4th ACTIVE cycle with 0xCAFEF00D.
//     -> m0 gets 0xCAFEF00D, timeout_err 0.
//  6. resetn low mid-ACTIVE.
//     -> mem_valid 0 immediately, no m*_mem_ready; after release, tie resolves to m0.
//  Formal (yosys-smtbmc): slave fields stable while mem_valid && !mem_ready; at most one m*_mem_ready.

Source files
------------

// File: rtl/picorv32_mem_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory interface.
// A grant lasts one full transaction; a wait-state watchdog ends hung slave accesses with an error read value.
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        grant_id,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        owner;
  logic        last_owner;
  logic        err_q;
  logic [15:0] wait_cnt;
  logic [31:0] rdata_q;
  logic        any_req;
  logic        sel;
  logic        timeout_hit;

  assign any_req     = m0_mem_valid | m1_mem_valid;
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    sel = m1_mem_valid;
    if (m0_mem_valid && m1_mem_valid) sel = ~last_owner;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACTIVE;
      ACTIVE:  if (mem_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      rdata_q    <= '0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= sel;
            wait_cnt  <= '0;
            mem_instr <= sel ? m1_mem_instr : m0_mem_instr;
            mem_addr  <= sel ? m1_mem_addr  : m0_mem_addr;
            mem_wdata <= sel ? m1_mem_wdata : m0_mem_wdata;
            mem_wstrb <= sel ? m1_mem_wstrb : m0_mem_wstrb;
          end
        end
        ACTIVE: begin
          // A slave response in the watchdog's final cycle still counts as a normal completion.
          if (mem_ready) begin
            rdata_q <= mem_rdata;
          end else if (timeout_hit) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          last_owner <= owner;
          err_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode directly from the state register so they fall with an async reset.
  assign mem_valid    = (state == ACTIVE);
  assign m0_mem_ready = (state == RESP) && !owner;
  assign m1_mem_ready = (state == RESP) &&  owner;
  assign m0_mem_rdata = rdata_q;
  assign m1_mem_rdata = rdata_q;
  assign timeout_err  = (state == RESP) && err_q;
  assign grant_id     = owner;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Self-checking bench: bench-driven masters and slave, transaction-level model predicting winner, latency and response.
module tb_picorv32_mem_arbiter;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0]  m0_mem_wstrb;
  logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m1_mem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        grant_id, busy, timeout_err;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Pending request of each master, held until its ready is seen.
  logic        rv [2];
  logic        ri [2];
  logic [31:0] ra [2];
  logic [31:0] rw [2];
  logic [3:0]  rs [2];
  bit          model_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    m0_mem_valid = rv[0]; m0_mem_instr = ri[0]; m0_mem_addr = ra[0];
    m0_mem_wdata = rw[0]; m0_mem_wstrb = rs[0];
    m1_mem_valid = rv[1]; m1_mem_instr = ri[1]; m1_mem_addr = ra[1];
    m1_mem_wdata = rw[1]; m1_mem_wstrb = rs[1];
  endtask

  task automatic new_req(input int m, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata, input logic instr);
    rv[m] = 1'b1; ra[m] = addr; rs[m] = strb; rw[m] = wdata; ri[m] = instr;
  endtask

  // One arbitration round. lat = ACTIVE cycle in which the slave answers (0 = never).
  task automatic serve(input int lat, input logic [31:0] sdata);
    int own, n;
    bit err;
    own = (rv[0] && rv[1]) ? (model_last ? 0 : 1) : (rv[0] ? 0 : 1);
    err = (lat == 0) || (lat > T);
    n   = err ? T : lat;
    drive();
    check("idle_busy", 32'(busy), 32'd0);
    cyc();
    for (int j = 1; j <= n; j++) begin
      check("act_valid", 32'(mem_valid), 32'd1);
      check("act_addr",  mem_addr,  ra[own]);
      check("act_wdata", mem_wdata, rw[own]);
      check("act_wstrb", 32'(mem_wstrb), 32'(rs[own]));
      check("act_instr", 32'(mem_instr), 32'(ri[own]));
      check("act_grant", 32'(grant_id), 32'(own));
      check("act_rdy",   32'({m1_mem_ready, m0_mem_ready}), 32'd0);
      check("act_terr",  32'(timeout_err), 32'd0);
      mem_ready = (j == lat);
      mem_rdata = (j == lat) ? sdata : $urandom();
      cyc();
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom();
    check("resp_valid", 32'(mem_valid), 32'd0);
    check("resp_rdy0",  32'(m0_mem_ready), 32'(own == 0));
    check("resp_rdy1",  32'(m1_mem_ready), 32'(own == 1));
    check("resp_rdata", (own == 0) ? m0_mem_rdata : m1_mem_rdata, err ? ERR : sdata);
    check("resp_terr",  32'(timeout_err), 32'(err));
    check("resp_grant", 32'(grant_id), 32'(own));
    rv[own] = 1'b0;
    drive();
    cyc();
    check("post_busy", 32'(busy), 32'd0);
    check("post_rdy",  32'({m1_mem_ready, m0_mem_ready}), 32'd0);
    check("post_terr", 32'(timeout_err), 32'd0);
    model_last = (own == 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      rv[m] = 1'b0; ri[m] = 1'b0; ra[m] = '0; rw[m] = '0; rs[m] = '0;
    end
    drive();
    mem_ready = 1'b0;
    mem_rdata = '0;
    resetn    = 1'b0;
    model_last = 1'b1;
    cyc(); cyc();
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_rdy",   32'({m1_mem_ready, m0_mem_ready}), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_terr",  32'(timeout_err), 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_rdata", m0_mem_rdata, 32'd0);
    resetn = 1'b1;
    cyc();

    // Simultaneous requests straight after reset: m0 first, then m1.
    new_req(0, 32'h10, 4'h0, 32'h0, 1'b1);
    new_req(1, 32'h20, 4'h0, 32'h0, 1'b0);
    serve(1, 32'h1111_0010);
    serve(2, 32'h2222_0020);

    // Single read, slave answers one cycle after mem_valid.
    new_req(0, 32'h100, 4'h0, 32'h0, 1'b0);
    serve(2, 32'h12345678);

    // Write from m1 with partial strobes.
    new_req(1, 32'h40, 4'b0011, 32'hA5A55A5A, 1'b0);
    serve(3, 32'h0BAD_0BAD);

    // Silent slave: watchdog completes after T cycles.
    new_req(0, 32'h200, 4'h0, 32'h0, 1'b0);
    serve(0, 32'h0);

    // Slave answers in the watchdog's final cycle: normal completion.
    new_req(0, 32'h204, 4'h0, 32'h0, 1'b0);
    serve(T, 32'hCAFEF00D);

    // Slave would answer one cycle too late.
    new_req(1, 32'h208, 4'hF, 32'h5555_AAAA, 1'b0);
    serve(T + 1, 32'h7777_7777);

    // Reset in the middle of an ACTIVE transaction.
    new_req(0, 32'h300, 4'h0, 32'h0, 1'b0);
    drive();
    cyc();
    check("mid_valid1", 32'(mem_valid), 32'd1);
    cyc();
    check("mid_valid2", 32'(mem_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", 32'(mem_valid), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_grant", 32'(grant_id), 32'd0);
    check("arst_rdy",   32'({m1_mem_ready, m0_mem_ready}), 32'd0);
    rv[0] = 1'b0;
    drive();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("arst_hold_rdy", 32'({m1_mem_ready, m0_mem_ready}), 32'd0);
    end
    resetn = 1'b1;
    model_last = 1'b1;
    cyc();
    check("post_rst_rdy", 32'({m1_mem_ready, m0_mem_ready}), 32'd0);
    new_req(0, 32'h400, 4'h0, 32'h0, 1'b0);
    new_req(1, 32'h500, 4'h0, 32'h0, 1'b1);
    serve(1, 32'h0000_0400);
    serve(3, 32'h0000_0500);

    // Randomized traffic against the transaction-level model.
    for (int it = 0; it < 60; it++) begin
      if (!rv[0] && !rv[1] && ($urandom_range(0, 3) == 0)) begin
        drive();
        cyc();
        check("gap_busy", 32'(busy), 32'd0);
      end
      for (int m = 0; m < 2; m++) begin
        if (!rv[m] && ($urandom_range(0, 1) == 1)) begin
          new_req(m, $urandom() & 32'hFFFF_FFFC,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0,
                  $urandom(), 1'($urandom()));
        end
      end
      if (!rv[0] && !rv[1]) begin
        new_req(int'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, 4'h0, $urandom(), 1'b0);
      end
      serve(int'($urandom_range(0, T + 2)), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
